pong_serve_ctrl: RTL

//   Consumes the free-running 9-bit pseudo-random word from the game LFSR and turns it into one ball

---
 rtl/pong_pkg.sv | 44 ++++
 rtl/pong_serve_ctrl_if.sv | 23 ++
 rtl/pong_rand_to_row.sv | 31 +++
 rtl/pong_serve_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong game encodings, geometry and serve FSM states
package pong_pkg;

  // Game-state encodings driven by the top-level game FSM
  localparam logic [1:0] GS_IDLE  = 2'd0;
  localparam logic [1:0] GS_PLAY  = 2'd1;
  localparam logic [1:0] GS_SCORE = 2'd2;
  localparam logic [1:0] GS_OVER  = 2'd3;

  // Playfield geometry
  localparam int GAME_HEIGHT = 30;
  localparam int Y_MARGIN    = 2;

  // Direction encodings
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  // Speed codes; 0 is never served
  localparam logic [1:0] SPEED_SLOW = 2'd1;
  localparam logic [1:0] SPEED_MED  = 2'd2;
  localparam logic [1:0] SPEED_FAST = 2'd3;

  // Serve FSM state encoding
  typedef logic [1:0] serve_state_t;
  localparam serve_state_t ST_IDLE  = 2'd0;
  localparam serve_state_t ST_WAIT  = 2'd1;
  localparam serve_state_t ST_OFFER = 2'd2;

  // Serve payload as offered to the ball controller
  typedef struct packed {
    logic [5:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic [1:0] speed;
  } serve_payload_t;

  // Speed code from two random bits, clamping the unusable zero code to the slowest speed
  function automatic logic [1:0] speed_from_bits(input logic [1:0] bits);
    return (bits == 2'd0) ? SPEED_SLOW : bits;
  endfunction

endpackage

// File: rtl/pong_serve_ctrl_if.sv
// rtl/pong_serve_ctrl_if.sv - serve payload valid/ready channel to the ball controller
interface pong_serve_ctrl_if;

  logic [5:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic [1:0] speed;
  logic       valid;
  logic       ready;

  // Serve controller side
  modport master (
    output ball_y, dir_x, dir_y, speed, valid,
    input  ready
  );

  // Ball-motion controller side
  modport slave (
    input  ball_y, dir_x, dir_y, speed, valid,
    output ready
  );

endinterface

// File: rtl/pong_rand_to_row.sv
// rtl/pong_rand_to_row.sv - folds a 6-bit random value into a legal start row
module pong_rand_to_row #(
  parameter int GAME_HEIGHT = 30,
  parameter int Y_MARGIN    = 2
) (
  input  logic [5:0] rand_v,
  output logic [5:0] row
);

  // Usable rows; the fold below only covers 0..63 when three spans reach 64
  localparam int ROWS = GAME_HEIGHT - 2 * Y_MARGIN;
  localparam logic [6:0] ROWS_1 = 7'(ROWS);
  localparam logic [6:0] ROWS_2 = 7'(2 * ROWS);

  logic [6:0] v_ext;
  logic [5:0] folded;

  // Modulo-ROWS by at most two conditional subtractions, then offset past the top margin
  always_comb begin
    v_ext = {1'b0, rand_v};
    if (v_ext >= ROWS_2) begin
      folded = 6'(v_ext - ROWS_2);
    end else if (v_ext >= ROWS_1) begin
      folded = 6'(v_ext - ROWS_1);
    end else begin
      folded = rand_v;
    end
    row = 6'(Y_MARGIN) + folded;
  end

endmodule

// File: rtl/pong_serve_ctrl.sv
// rtl/pong_serve_ctrl.sv - turns an LFSR word into a delayed, handshaked ball serve
module pong_serve_ctrl #(
  parameter int          GAME_HEIGHT = pong_pkg::GAME_HEIGHT,
  parameter int          Y_MARGIN    = pong_pkg::Y_MARGIN,
  parameter int unsigned SERVE_DELAY = 25000000
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic [1:0]               i_state,
  input  logic [8:0]               i_rand,
  input  logic                     i_serve_req,
  input  logic                     i_last_winner,
  pong_serve_ctrl_if.master        srv,
  output logic                     o_busy,
  output logic [7:0]               o_serve_cnt
);

  import pong_pkg::*;

  serve_state_t   state;
  logic [31:0]    dly_cnt;
  logic           valid_q;
  logic [7:0]     serve_cnt_q;
  serve_payload_t payload_q;
  serve_payload_t payload_d;
  logic [5:0]     row_d;

  pong_rand_to_row #(
    .GAME_HEIGHT (GAME_HEIGHT),
    .Y_MARGIN    (Y_MARGIN)
  ) u_row (
    .rand_v (i_rand[8:3]),
    .row    (row_d)
  );

  // Payload as it would be captured from the current LFSR word and winner
  always_comb begin
    payload_d.ball_y = row_d;
    payload_d.dir_x  = ~i_last_winner;
    payload_d.dir_y  = i_rand[0];
    payload_d.speed  = speed_from_bits(i_rand[2:1]);
  end

  // Serve FSM: capture on request, count down the delay, offer until accepted; idle game clears
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      valid_q     <= 1'b0;
      serve_cnt_q <= '0;
      payload_q   <= '0;
    end else if (i_state == GS_IDLE) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      valid_q     <= 1'b0;
      serve_cnt_q <= '0;
      payload_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_serve_req) begin
            payload_q <= payload_d;
            dly_cnt   <= SERVE_DELAY;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dly_cnt == 32'd0) begin
            state   <= ST_OFFER;
            valid_q <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end
        ST_OFFER: begin
          if (srv.ready) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
            if (serve_cnt_q != 8'hFF) begin
              serve_cnt_q <= serve_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign srv.ball_y  = payload_q.ball_y;
  assign srv.dir_x   = payload_q.dir_x;
  assign srv.dir_y   = payload_q.dir_y;
  assign srv.speed   = payload_q.speed;
  assign srv.valid   = valid_q;
  assign o_busy      = (state != ST_IDLE);
  assign o_serve_cnt = serve_cnt_q;

endmodule
